tx_frame_scheduler: RTL and testbench

Sequences and shares the 10BASE-T UDP transmitter among several local data producers. Requesters win the transmitter by round-robin arbitration, stream a fixed-size payload into a frame buffer, and the scheduler prepends a 2-byte header and issues a single start pulse. It then holds the buffer stable for the transmitter's payload reads until the frame completes. A minimum inter-frame gap is enforced before the next grant. The block replaces the free-running once-per-second trigger with demand-driven sending.

---
 rtl/tx_frame_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: shares one UDP transmitter among NREQ producers.
// A round-robin winner streams PAYLOAD_BYTES into a frame buffer behind a
// 2-byte header {winner index, seq}. The block then pulses tx_start once,
// holds the buffer stable while the transmitter reads it, and enforces an
// inter-frame gap before the next grant.
// Ports:
//   clk20, rst            20 MHz clock, async active-high reset
//   req[NREQ]  / gnt      level requests in, one-hot registered grant out
//   in_data/in_valid      payload bytes from the granted requester
//   in_ready              registered byte-accept strobe
//   tx_start / tx_busy    one-cycle start pulse out, transmitter busy in
//   rd_addr / rd_data     transmitter payload read port, 1-cycle latency
//   sched_busy            high whenever the scheduler is not idle
//   err_timeout           sticky: tx_busy never rose after tx_start
//   seq                   sequence number of the next frame
module tx_frame_scheduler #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned PAYLOAD_BYTES = 16,
  parameter int unsigned GAP_CYCLES    = 256,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic            clk20,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            tx_start,
  input  logic            tx_busy,
  input  logic [4:0]      rd_addr,
  output logic [7:0]      rd_data,
  output logic            sched_busy,
  output logic            err_timeout,
  output logic [7:0]      seq
);

  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES + 2;
  localparam int unsigned IDXW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW          = $clog2(FRAME_BYTES);
  localparam int unsigned CW          = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned TMAX        = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int unsigned TW          = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_SEND, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            in_ready_q, in_ready_d;
  logic            tx_start_q, tx_start_d;
  logic            sched_busy_q, sched_busy_d;
  logic            err_q, err_d;
  logic [7:0]      seq_q, seq_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [7:0]      frame_q [FRAME_BYTES];

  logic            found;
  logic [IDXW-1:0] pick;
  logic            hdr_we;
  logic            dat_we;
  logic            accept;

  assign accept = in_valid & in_ready_q;

  // Round-robin search starting just after the previous winner.
  always_comb begin : arb
    int j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      j = int'(last_q) + i;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      if (!found && req[IDXW'(j)]) begin
        found = 1'b1;
        pick  = IDXW'(j);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    in_ready_d = 1'b0;
    tx_start_d = 1'b0;
    err_d      = err_q;
    seq_d      = seq_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    tmr_d      = tmr_q;
    hdr_we     = 1'b0;
    dat_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d    = S_LOAD;
          gnt_d      = NREQ'(1) << pick;
          last_d     = pick;
          byte_cnt_d = '0;
          hdr_we     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (accept) begin
          dat_we     = 1'b1;
          byte_cnt_d = byte_cnt_q + CW'(1);
          // Last byte: drop grant/ready and fire the start pulse together.
          if (byte_cnt_q == CW'(PAYLOAD_BYTES - 1)) begin
            state_d    = S_START;
            gnt_d      = '0;
            in_ready_d = 1'b0;
            tx_start_d = 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
        tmr_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_SEND;
        end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          seq_d   = seq_q + 8'd1;
          state_d = S_GAP;
          tmr_d   = '0;
        end
      end
      S_GAP: begin
        if (tmr_q == TW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                              tmr_d   = tmr_q + TW'(1);
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    sched_busy_d = (state_d != S_IDLE);
  end

  // Out-of-range reads return zero.
  always_comb begin
    rd_data_d = 8'h00;
    if (32'(rd_addr) < FRAME_BYTES) rd_data_d = frame_q[BW'(rd_addr)];
  end

  always_ff @(posedge clk20 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      in_ready_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      sched_busy_q <= 1'b0;
      err_q        <= 1'b0;
      seq_q        <= 8'h00;
      last_q       <= IDXW'(NREQ - 1);
      byte_cnt_q   <= '0;
      tmr_q        <= '0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      in_ready_q   <= in_ready_d;
      tx_start_q   <= tx_start_d;
      sched_busy_q <= sched_busy_d;
      err_q        <= err_d;
      seq_q        <= seq_d;
      last_q       <= last_d;
      byte_cnt_q   <= byte_cnt_d;
      tmr_q        <= tmr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Frame buffer: no reset, written only on LOAD entry and during LOAD.
  always_ff @(posedge clk20) begin
    if (hdr_we) begin
      frame_q[0] <= 8'(pick);
      frame_q[1] <= seq_q;
    end
    if (dat_we) frame_q[BW'(byte_cnt_q) + BW'(2)] <= in_data;
  end

  assign gnt         = gnt_q;
  assign in_ready    = in_ready_q;
  assign tx_start    = tx_start_q;
  assign rd_data     = rd_data_q;
  assign sched_busy  = sched_busy_q;
  assign err_timeout = err_q;
  assign seq         = seq_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a simple transmitter model.
module tb_tx_frame_scheduler;

  logic       clk20 = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       sched_busy;
  logic       err_timeout;
  logic [7:0] seq;

  int checks = 0;
  int failures = 0;

  // Transmitter model: busy rises 2 cycles after tx_start, lasts tx_len cycles.
  int tx_dly = 0;
  int tx_rem = 0;
  int tx_len = 20;
  bit tx_en  = 1'b1;

  tx_frame_scheduler #(
    .NREQ(4), .PAYLOAD_BYTES(16), .GAP_CYCLES(256), .START_TIMEOUT(8)
  ) dut (
    .clk20(clk20), .rst(rst), .req(req), .gnt(gnt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_start(tx_start), .tx_busy(tx_busy),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .sched_busy(sched_busy), .err_timeout(err_timeout), .seq(seq)
  );

  always #25 clk20 = ~clk20;

  always @(negedge clk20) begin
    if (tx_rem > 0) begin
      tx_rem = tx_rem - 1;
      if (tx_rem == 0) tx_busy = 1'b0;
    end else if (tx_dly > 0) begin
      tx_dly = tx_dly - 1;
      if (tx_dly == 0) begin
        tx_busy = 1'b1;
        tx_rem  = tx_len;
      end
    end else if (tx_start && tx_en) begin
      tx_dly = 2;
    end
  end

  task automatic tick();
    @(posedge clk20);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_dly = 0; tx_rem = 0; tx_busy = 1'b0;
    req = '0; in_valid = 1'b0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_gnt(output bit ok);
    int n = 0;
    while (gnt === 4'b0000 && n < 3000) begin tick(); n++; end
    ok = (gnt !== 4'b0000);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (sched_busy !== 1'b0 && n < 4000) begin tick(); n++; end
    ok = (sched_busy === 1'b0);
  endtask

  // Called in the first grant cycle; returns in the tx_start cycle.
  task automatic load_bytes(input logic [7:0] base);
    for (int k = 0; k < 16; k++) begin
      in_data  = base + 8'(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (seq !== 8'h00) begin failures++; $display("FAIL reset_seq got=%h exp=00", seq); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", sched_busy); end
  endtask

  task automatic test_single();
    logic [7:0] d, e;
    int n;
    tx_len = 1168;
    req = 4'b0100; in_valid = 1'b1; in_data = 8'h10;
    tick();  // cycle 1
    req = 4'b0000;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt_c1 got=%b exp=0100", gnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_c1 got=%b exp=1", in_ready); end
    checks++; if (sched_busy !== 1'b1) begin failures++; $display("FAIL single_busy_c1 got=%b exp=1", sched_busy); end
    for (int k = 1; k < 16; k++) begin
      tick();
      in_data = 8'h10 + 8'(k);
    end
    // cycle 16: last byte on the bus
    checks++; if (tx_start !== 1'b0 || gnt !== 4'b0100) begin failures++; $display("FAIL single_c16 tx_start=%b gnt=%b exp 0/0100", tx_start, gnt); end
    tick();  // cycle 17
    in_valid = 1'b0;
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_tx_start_c17 got=%b exp=1", tx_start); end
    checks++; if (gnt !== 4'b0000 || in_ready !== 1'b0) begin failures++; $display("FAIL single_c17_gnt got=%b/%b exp=0000/0", gnt, in_ready); end
    tick();  // cycle 18
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_tx_start_c18 got=%b exp=0", tx_start); end
    for (int a = 0; a <= 18; a++) begin
      if (a == 0) e = 8'h02;
      else if (a == 1) e = 8'h00;
      else if (a <= 17) e = 8'h10 + 8'(a - 2);
      else e = 8'h00;
      read_byte(5'(a), d);
      checks++; if (d !== e) begin failures++; $display("FAIL single_rd addr=%0d got=%h exp=%h", a, d, e); end
    end
    n = 0;
    while (seq !== 8'h01 && n < 3000) begin tick(); n++; end
    checks++; if (seq !== 8'h01) begin failures++; $display("FAIL single_seq got=%h exp=01", seq); end
    // First GAP cycle now; IDLE returns 256 cycles later.
    checks++; if (tx_busy !== 1'b0 || sched_busy !== 1'b1) begin failures++; $display("FAIL single_gap_entry tx_busy=%b sched_busy=%b exp 0/1", tx_busy, sched_busy); end
    for (int k = 0; k < 255; k++) tick();
    checks++; if (sched_busy !== 1'b1) begin failures++; $display("FAIL single_gap_255 got=%b exp=1", sched_busy); end
    tick();
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL single_gap_256 got=%b exp=0", sched_busy); end
    tx_len = 20;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] d;
    logic [3:0] eg;
    do_reset();
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(ok);
      eg = 4'b0001 << (f % 4);
      checks++; if (!ok || gnt !== eg) begin failures++; $display("FAIL rr_gnt frame=%0d got=%b exp=%b", f, gnt, eg); end
      load_bytes(8'h40 + 8'(f * 16));
      if (f == 4) req = 4'b0000;
      checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL rr_tx_start frame=%0d got=%b exp=1", f, tx_start); end
      read_byte(5'd1, d);
      checks++; if (d !== 8'(f)) begin failures++; $display("FAIL rr_seq_hdr frame=%0d got=%h exp=%h", f, d, 8'(f)); end
      read_byte(5'd0, d);
      checks++; if (d !== 8'(f % 4)) begin failures++; $display("FAIL rr_idx_hdr frame=%0d got=%h exp=%h", f, d, 8'(f % 4)); end
    end
  endtask

  task automatic test_gapped();
    bit ok;
    logic [7:0] d;
    int bad = 0;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL gapped_idle timeout sched_busy=%b", sched_busy); end
    req = 4'b0010; in_valid = 1'b0;
    tick();  // cycle 1
    for (int c = 1; c <= 31; c++) begin
      in_valid = (c % 2) == 1;
      in_data  = 8'hA0 + 8'((c - 1) / 2);
      if (c == 8) req = 4'b0000;
      if (gnt !== 4'b0010 || tx_start !== 1'b0) bad++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL gapped_hold bad_cycles=%0d exp=0", bad); end
    checks++; if (tx_start !== 1'b1 || gnt !== 4'b0000 || in_ready !== 1'b0) begin failures++; $display("FAIL gapped_c32 tx_start=%b gnt=%b in_ready=%b exp 1/0000/0", tx_start, gnt, in_ready); end
    read_byte(5'd0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL gapped_idx got=%h exp=01", d); end
    read_byte(5'd1, d);
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL gapped_seq got=%h exp=05", d); end
    read_byte(5'd2, d);
    checks++; if (d !== 8'hA0) begin failures++; $display("FAIL gapped_b0 got=%h exp=a0", d); end
    read_byte(5'd17, d);
    checks++; if (d !== 8'hAF) begin failures++; $display("FAIL gapped_b15 got=%h exp=af", d); end
  endtask

  task automatic test_timeout();
    bit ok;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_idle timeout sched_busy=%b", sched_busy); end
    tx_en = 1'b0;
    req = 4'b0001;
    wait_gnt(ok);
    checks++; if (!ok || gnt !== 4'b0001) begin failures++; $display("FAIL timeout_gnt got=%b exp=0001", gnt); end
    load_bytes(8'h60);  // cycle 17
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL timeout_tx_start got=%b exp=1", tx_start); end
    for (int k = 0; k < 8; k++) tick();  // cycle 25
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_err_c25 got=%b exp=0", err_timeout); end
    tick();  // cycle 26, first GAP cycle
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_err_c26 got=%b exp=1", err_timeout); end
    checks++; if (seq !== 8'h06) begin failures++; $display("FAIL timeout_seq got=%h exp=06", seq); end
    for (int k = 0; k < 256; k++) tick();  // cycle 282, IDLE
    checks++; if (gnt !== 4'b0000 || sched_busy !== 1'b0) begin failures++; $display("FAIL timeout_gap_end gnt=%b sched_busy=%b exp 0000/0", gnt, sched_busy); end
    tick();  // cycle 283
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL timeout_regrant got=%b exp=0001", gnt); end
    tx_en = 1'b1;
    req = 4'b0000;
    load_bytes(8'h70);
    wait_idle(ok);
    checks++; if (!ok || seq !== 8'h07 || err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_after seq=%h err=%b exp 07/1", seq, err_timeout); end
  endtask

  task automatic test_req_during_send();
    bit ok;
    logic [7:0] d;
    int bad = 0;
    int n = 0;
    req = 4'b0100;
    wait_gnt(ok);
    checks++; if (!ok || gnt !== 4'b0100) begin failures++; $display("FAIL rds_gnt1 got=%b exp=0100", gnt); end
    load_bytes(8'h80);
    req = 4'b1111;
    while (sched_busy !== 1'b0 && n < 4000) begin
      if (gnt !== 4'b0000) bad++;
      tick(); n++;
    end
    checks++; if (bad !== 0 || sched_busy !== 1'b0) begin failures++; $display("FAIL rds_no_gnt bad_cycles=%0d sched_busy=%b exp 0/0", bad, sched_busy); end
    tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rds_resume got=%b exp=1000", gnt); end
    req = 4'b0000;
    load_bytes(8'h90);
    read_byte(5'd0, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL rds_idx got=%h exp=03", d); end
    read_byte(5'd1, d);
    checks++; if (d !== 8'h08) begin failures++; $display("FAIL rds_seq got=%h exp=08", d); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    logic [7:0] d;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rml_idle timeout sched_busy=%b", sched_busy); end
    req = 4'b0010;
    wait_gnt(ok);
    checks++; if (!ok || gnt !== 4'b0010) begin failures++; $display("FAIL rml_gnt got=%b exp=0010", gnt); end
    for (int k = 0; k < 7; k++) begin
      in_data = 8'hC0 + 8'(k); in_valid = 1'b1;
      tick();
    end
    in_data = 8'hC7;  // byte 7 on the bus
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000 || in_ready !== 1'b0 || tx_start !== 1'b0) begin failures++; $display("FAIL rml_ctl gnt=%b in_ready=%b tx_start=%b exp 0000/0/0", gnt, in_ready, tx_start); end
    checks++; if (rd_data !== 8'h00 || seq !== 8'h00 || err_timeout !== 1'b0 || sched_busy !== 1'b0) begin failures++; $display("FAIL rml_stat rd=%h seq=%h err=%b busy=%b exp 00/00/0/0", rd_data, seq, err_timeout, sched_busy); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    req = 4'b1111;
    wait_gnt(ok);
    checks++; if (!ok || gnt !== 4'b0001) begin failures++; $display("FAIL rml_regrant got=%b exp=0001", gnt); end
    req = 4'b0000;
    load_bytes(8'hD0);
    read_byte(5'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rml_seq got=%h exp=00", d); end
    read_byte(5'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rml_idx got=%h exp=00", d); end
    wait_idle(ok);
    checks++; if (!ok || seq !== 8'h01) begin failures++; $display("FAIL rml_end seq=%h exp=01", seq); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gapped();
    test_timeout();
    test_req_during_send();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
